// File: rtl/pebble_pkg.sv
// Shared types and instruction field layout for the pebble multi-cycle core.
// The 9-bit instruction word is split into a 2-bit type and a 7-bit payload.
package pebble_pkg;

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StDone} state_e;

  typedef enum logic [1:0] {InsnR = 2'b00, InsnI = 2'b01, InsnM = 2'b10, InsnB = 2'b11} insn_e;

  typedef enum logic [2:0] {
    AluAdd  = 3'b000,
    AluSub  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011,
    AluXor  = 3'b100,
    AluShl  = 3'b101,
    AluShr  = 3'b110,
    AluPass = 3'b111
  } alu_op_e;

  localparam int unsigned IrW      = 9;
  localparam int unsigned TypeLsb  = 7;  // IR[8:7]
  localparam int unsigned FlagBit  = 6;  // load (M) / halt (B)
  localparam int unsigned FuncLsb  = 4;  // IR[6:4]
  localparam int unsigned IRdLsb   = 5;  // IR[6:5]
  localparam int unsigned ImmW     = 5;  // IR[4:0]
  localparam int unsigned HiRegLsb = 4;  // IR[5:4]: M data reg, B target reg
  localparam int unsigned SrcALsb  = 2;  // IR[3:2]: rd/rs1, M addr reg, B ra
  localparam int unsigned SrcBLsb  = 0;  // IR[1:0]: rs2, B rb

  function automatic logic [1:0] reg_field(logic [IrW-1:0] ir, int unsigned lsb);
    return ir[lsb +: 2];
  endfunction

endpackage

// File: rtl/pebble_alu_p.sv
// Combinational ALU; the zero flag doubles as the equality test for branches.
module pebble_alu_p
  import pebble_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          zero
);

  always_comb begin
    y = '0;
    unique case (alu_op_e'(op))
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluXor:  y = a ^ b;
      AluShl:  y = a << 1;
      AluShr:  y = a >> 1;
      AluPass: y = b;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/pebble_core_mc.sv
// Multi-cycle pebble core: fetch / execute / memory FSM, 4-entry register file and PC.
// All bus outputs are registered; imem_addr is the PC register itself.
module pebble_core_mc
  import pebble_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned PCW = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           done,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [8:0]     imem_rdata,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_valid,
  input  logic [DW-1:0]  dmem_rdata
);

  state_e         state;
  logic [PCW-1:0] pc;
  logic [IrW-1:0] ir;
  logic [DW-1:0]  rf [4];

  insn_e          itype;
  logic           flag;
  logic [1:0]     src_a, src_b, hi_reg, i_rd;
  logic [2:0]     alu_op;
  logic [DW-1:0]  alu_y, imm_ext;
  logic           alu_zero;
  logic [PCW-1:0] pc_inc, br_target;

  assign itype     = insn_e'(ir[TypeLsb +: 2]);
  assign flag      = ir[FlagBit];
  assign src_a     = reg_field(ir, SrcALsb);
  assign src_b     = reg_field(ir, SrcBLsb);
  assign hi_reg    = reg_field(ir, HiRegLsb);
  assign i_rd      = reg_field(ir, IRdLsb);
  assign imm_ext   = {{(DW-ImmW){1'b0}}, ir[ImmW-1:0]};
  assign pc_inc    = pc + {{(PCW-1){1'b0}}, 1'b1};
  assign br_target = PCW'(rf[hi_reg]);
  assign imem_addr = pc;
  // Branches reuse the ALU subtract: equal operands give a zero result.
  assign alu_op    = (itype == InsnR) ? ir[FuncLsb +: 3] : 3'(AluSub);

  pebble_alu_p #(
    .DW(DW)
  ) u_alu (
    .op  (alu_op),
    .a   (rf[src_a]),
    .b   (rf[src_b]),
    .y   (alu_y),
    .zero(alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= StIdle;
      pc         <= '0;
      ir         <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      done       <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            pc       <= '0;
            done     <= 1'b0;
            imem_req <= 1'b1;
            state    <= StFetch;
          end
        end
        StFetch: begin
          if (imem_valid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= StExec;
          end
        end
        StExec: begin
          unique case (itype)
            InsnR: begin
              rf[src_a] <= alu_y;
              pc        <= pc_inc;
              imem_req  <= 1'b1;
              state     <= StFetch;
            end
            InsnI: begin
              rf[i_rd] <= imm_ext;
              pc       <= pc_inc;
              imem_req <= 1'b1;
              state    <= StFetch;
            end
            InsnM: begin
              dmem_req   <= 1'b1;
              dmem_we    <= ~flag;
              dmem_addr  <= rf[src_a];
              dmem_wdata <= rf[hi_reg];
              state      <= StMem;
            end
            InsnB: begin
              if (flag) begin
                done  <= 1'b1;
                state <= StDone;
              end else begin
                pc       <= alu_zero ? br_target : pc_inc;
                imem_req <= 1'b1;
                state    <= StFetch;
              end
            end
          endcase
        end
        StMem: begin
          if (dmem_valid) begin
            if (flag) rf[hi_reg] <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            pc       <= pc_inc;
            imem_req <= 1'b1;
            state    <= StFetch;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
